// File: rtl/rv32im_soc.sv
// Board-level bring-up shell: cycle counter on HEX, switch/LED mirroring, 640x480 VGA test
// patterns, and SRAM/LCD pins parked in safe idle states.
module rv32im_soc #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_TOTAL  = 525
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_CLK,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic [7:0]  RED,
   output logic [7:0]  GREEN,
   output logic [7:0]  BLUE,
   output logic [8:0]  LEDG,
   output logic [17:0] LEDR,
   input  logic [17:0] SW,
   output logic [19:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_UB_N,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic [6:0]  HEX6,
   output logic [6:0]  HEX7,
   output logic        LCD_BLON,
   output logic        LCD_ON,
   output logic        LCD_EN,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic [7:0]  LCD_DATA
);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + 16);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + 111);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + 10);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + 11);

   logic [31:0] cnt_q;
   logic [17:0] ledr_q;
   logic        pclk_q;
   logic [9:0]  hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        blank_n_q, blank_n_d;
   logic [23:0] rgb_q, rgb_d;
   logic [2:0]  bar;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Sync/blank/colour are registered from the next-state counters so they line up with hcnt_q/vcnt_q.
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (pclk_q) begin
         if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end
      end

      hs_d      = !((hcnt_d >= HS_START) && (hcnt_d <= HS_END));
      vs_d      = !((vcnt_d >= VS_START) && (vcnt_d <= VS_END));
      blank_n_d = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
      bar       = 3'(hcnt_d / 10'd80);

      rgb_d = '0;
      if (blank_n_d) begin
         unique case (SW[1:0])
            2'b00: rgb_d = '0;
            2'b01: rgb_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            2'b10: rgb_d = {SW[17:15], 5'b0, SW[14:12], 5'b0, SW[11:10], 6'b0};
            default: rgb_d = {24{hcnt_d[5] ^ vcnt_d[5]}};
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESETN) begin
      if (ARESETN) begin
         cnt_q     <= '0;
         ledr_q    <= '0;
         pclk_q    <= 1'b0;
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         rgb_q     <= '0;
      end else begin
         cnt_q     <= cnt_q + 32'd1;
         ledr_q    <= SW;
         pclk_q    <= ~pclk_q;
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         blank_n_q <= blank_n_d;
         rgb_q     <= rgb_d;
      end
   end

   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_CLK     = pclk_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_SYNC_N  = 1'b0;
   assign RED         = rgb_q[23:16];
   assign GREEN       = rgb_q[15:8];
   assign BLUE        = rgb_q[7:0];

   assign LEDR = ledr_q;
   assign LEDG = {cnt_q[25], cnt_q[31:24]};

   assign HEX0 = hex7(cnt_q[3:0]);
   assign HEX1 = hex7(cnt_q[7:4]);
   assign HEX2 = hex7(cnt_q[11:8]);
   assign HEX3 = hex7(cnt_q[15:12]);
   assign HEX4 = hex7(cnt_q[19:16]);
   assign HEX5 = hex7(cnt_q[23:20]);
   assign HEX6 = hex7(cnt_q[27:24]);
   assign HEX7 = hex7(cnt_q[31:28]);

   // Memory and LCD parked until the core and memory controller are attached.
   assign SRAM_ADDR = '0;
   assign SRAM_DQ   = 16'bz;
   assign SRAM_CE_N = 1'b1;
   assign SRAM_OE_N = 1'b1;
   assign SRAM_WE_N = 1'b1;
   assign SRAM_LB_N = 1'b1;
   assign SRAM_UB_N = 1'b1;
   assign LCD_BLON  = 1'b1;
   assign LCD_ON    = 1'b1;
   assign LCD_EN    = 1'b0;
   assign LCD_RS    = 1'b0;
   assign LCD_RW    = 1'b0;
   assign LCD_DATA  = '0;

endmodule

// File: tb/tb_rv32im_soc.sv
// Randomized self-checking bench for rv32im_soc; a short frame (20 lines) keeps the VS and
// mid-frame reset scenarios within a small cycle budget.
module tb_rv32im_soc;

   localparam int VA = 8;
   localparam int VT = 20;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b1;
   logic [17:0] SW = '0;
   logic        VGA_HS, VGA_VS, VGA_CLK, VGA_BLANK_N, VGA_SYNC_N;
   logic [7:0]  RED, GREEN, BLUE;
   logic [8:0]  LEDG;
   logic [17:0] LEDR;
   logic [19:0] SRAM_ADDR;
   wire  [15:0] SRAM_DQ;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
   logic        LCD_BLON, LCD_ON, LCD_EN, LCD_RS, LCD_RW;
   logic [7:0]  LCD_DATA;

   rv32im_soc #(
      .H_ACTIVE(640),
      .H_TOTAL (800),
      .V_ACTIVE(VA),
      .V_TOTAL (VT)
   ) dut (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .VGA_HS     (VGA_HS),
      .VGA_VS     (VGA_VS),
      .VGA_CLK    (VGA_CLK),
      .VGA_BLANK_N(VGA_BLANK_N),
      .VGA_SYNC_N (VGA_SYNC_N),
      .RED        (RED),
      .GREEN      (GREEN),
      .BLUE       (BLUE),
      .LEDG       (LEDG),
      .LEDR       (LEDR),
      .SW         (SW),
      .SRAM_ADDR  (SRAM_ADDR),
      .SRAM_DQ    (SRAM_DQ),
      .SRAM_CE_N  (SRAM_CE_N),
      .SRAM_OE_N  (SRAM_OE_N),
      .SRAM_WE_N  (SRAM_WE_N),
      .SRAM_LB_N  (SRAM_LB_N),
      .SRAM_UB_N  (SRAM_UB_N),
      .HEX0       (HEX0),
      .HEX1       (HEX1),
      .HEX2       (HEX2),
      .HEX3       (HEX3),
      .HEX4       (HEX4),
      .HEX5       (HEX5),
      .HEX6       (HEX6),
      .HEX7       (HEX7),
      .LCD_BLON   (LCD_BLON),
      .LCD_ON     (LCD_ON),
      .LCD_EN     (LCD_EN),
      .LCD_RS     (LCD_RS),
      .LCD_RW     (LCD_RW),
      .LCD_DATA   (LCD_DATA)
   );

   always #5 ACLK = ~ACLK;

   int          n_checks = 0;
   int          n_errors = 0;
   int          t;
   logic [17:0] sw_edge;
   logic        hs_prev, vs_prev;
   int          last_hs_fall, last_vs_fall;
   bit          hs_seen, vs_seen;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   function automatic logic [6:0] seg(input int n);
      logic [6:0] tbl [16];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return tbl[n];
   endfunction

   function automatic logic [55:0] hex_model(input logic [31:0] c);
      logic [55:0] v;
      for (int k = 0; k < 8; k++) v[7*k +: 7] = seg(int'((c >> (4 * k)) & 32'hF));
      return v;
   endfunction

   function automatic logic [23:0] rgb_model(input int h, input int v, input logic [17:0] sw);
      int bar;
      bar = h / 80;
      if (!(h < 640 && v < VA)) return 24'h0;
      case (sw[1:0])
         2'b00: return 24'h0;
         2'b01: return {((bar / 4) % 2 == 1) ? 8'hFF : 8'h00,
                        ((bar / 2) % 2 == 1) ? 8'hFF : 8'h00,
                        (bar % 2 == 1) ? 8'hFF : 8'h00};
         2'b10: return {8'(((sw >> 15) & 7) * 32), 8'(((sw >> 12) & 7) * 32),
                        8'(((sw >> 10) & 3) * 64)};
         default: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h0;
      endcase
   endfunction

   task automatic const_checks();
      check("sram_addr", 64'(SRAM_ADDR), 64'h0);
      check("sram_dq", 64'(SRAM_DQ), 64'(16'bz));
      check("sram_ctl", 64'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}), 64'h1F);
      check("lcd", 64'({LCD_BLON, LCD_ON, LCD_EN, LCD_RS, LCD_RW, LCD_DATA}), 64'({5'b11000, 8'h0}));
      check("vga_sync_n", 64'(VGA_SYNC_N), 64'h0);
   endtask

   task automatic reset_checks();
      check("rst_hex", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {8{7'h40}});
      check("rst_led", 64'({LEDG, LEDR}), 64'h0);
      check("rst_vga", 64'({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, RED, GREEN, BLUE}),
            64'({4'b1100, 24'h0}));
   endtask

   task automatic release_reset();
      @(negedge ACLK);
      ARESETN      = 1'b0;
      t            = 0;
      hs_prev      = 1'b1;
      vs_prev      = 1'b1;
      hs_seen      = 1'b0;
      vs_seen      = 1'b0;
      last_hs_fall = 0;
      last_vs_fall = 0;
   endtask

   task automatic step();
      int          h, v;
      logic [31:0] c;
      logic        e_hs, e_vs, e_bl;
      @(posedge ACLK);
      sw_edge = SW;
      t++;
      #1;
      c    = 32'(t);
      h    = (t / 2) % 800;
      v    = (t / 1600) % VT;
      e_hs = !(h >= 656 && h <= 751);
      e_vs = !(v >= VA + 10 && v <= VA + 11);
      e_bl = (h < 640) && (v < VA);
      check("hex", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, hex_model(c));
      check("ledr", 64'(LEDR), 64'(sw_edge));
      check("ledg", 64'(LEDG), 64'({c[25], c[31:24]}));
      check("vga_clk", 64'(VGA_CLK), 64'(t % 2));
      check("vga", 64'({VGA_HS, VGA_VS, VGA_BLANK_N, RED, GREEN, BLUE}),
            64'({e_hs, e_vs, e_bl, rgb_model(h, v, sw_edge)}));

      if (hs_prev && !VGA_HS) begin
         if (!hs_seen) check("hs_first_fall", 64'(t), 64'd1312);
         else          check("hs_period", 64'(t - last_hs_fall), 64'd1600);
         hs_seen      = 1'b1;
         last_hs_fall = t;
      end
      if (!hs_prev && VGA_HS && hs_seen) check("hs_low", 64'(t - last_hs_fall), 64'd192);
      if (vs_prev && !VGA_VS) begin
         check("vs_first_fall", 64'(t), 64'((VA + 10) * 1600));
         vs_seen      = 1'b1;
         last_vs_fall = t;
      end
      if (!vs_prev && VGA_VS && vs_seen) check("vs_low", 64'(t - last_vs_fall), 64'd3200);
      hs_prev = VGA_HS;
      vs_prev = VGA_VS;

      if (t % 37 == 0) SW = 18'($urandom);
   endtask

   initial begin
      t = 0;
      repeat (10) @(posedge ACLK);
      #1;
      reset_checks();
      const_checks();

      release_reset();
      for (int i = 0; i < 100; i++) step();
      check("hex_after_100", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
            {{6{7'h40}}, 7'h02, 7'h19});

      SW = 18'h2A5A5;
      step();
      check("sw_mirror", 64'(LEDR), 64'h2A5A5);

      // Force colour bars across a full line so the 560-pixel white bar is seen.
      SW = 18'h00001;
      while (t < 1700) begin
         step();
         SW[1:0] = 2'b01;
         if (t == 1120 + 1) check("bar_560", 64'({RED, GREEN, BLUE}), 64'hFFFFFF);
      end

      // Stop inside both sync pulses (line 18, pixel 700), then reset asynchronously.
      while (t < 30200) step();
      check("pre_rst_sync", 64'({VGA_HS, VGA_VS}), 64'h0);
      ARESETN = 1'b1;
      #1;
      reset_checks();
      repeat (3) @(posedge ACLK);
      #1;
      reset_checks();

      release_reset();
      while (t < 33000) step();
      check("vs_fell_after_rst", 64'(vs_seen), 64'h1);
      const_checks();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
